tick_sched: RTL and testbench
=============================

TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 Parameter CNT_W, default 28, sets the width of the shared period counter and of each period field.
REQ-002 Parameter NREQ, default 4, sets the number of requesters; the only supported value is 4.
REQ-003 Port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port tick_in, input, 1 bit: one-cycle clock-enable pulse from the prescaler; it is the count event.
REQ-006 Port req, input, 4 bits: per-requester timer request, level; held high until done or abort.
REQ-007 Port period, input, 4*CNT_W bits: packed periods; field i is bits [i*CNT_W +: CNT_W], sampled at grant.
REQ-008 Port gnt, output, 4 bits: one-hot grant of the shared counter, or all zero.
REQ-009 Port done, output, 4 bits: one-cycle completion pulse for the granted requester.
REQ-010 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 Port cur_id, output, 2 bits: index of the current or last granted requester.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, GRANT, COUNT and DONE.
REQ-013 IDLE -> GRANT SHALL occur on the cycle after any req bit is sampled high.
  - The winner is latched into cur_id.
  - gnt[winner] is set from the same edge.
REQ-014 In GRANT (1 cycle), the counter SHALL load period[cur_id]-1 and the next state SHALL be COUNT.
  - If period[cur_id]==0, the next state SHALL be DONE instead, with no tick consumed.
REQ-015 In COUNT, the counter SHALL decrement by 1 only on cycles where tick_in=1.
REQ-016 In COUNT, when counter==0 and tick_in=1, the next state SHALL be DONE.
  - A period of P (P>=1) therefore completes on the P-th tick_in after GRANT.
REQ-017 In DONE (1 cycle), done[cur_id]=1, gnt SHALL be all zero, and the next state SHALL be IDLE.
REQ-018 gnt[cur_id] SHALL be high throughout GRANT and COUNT and low in IDLE and DONE.
REQ-019 Abort: if req[cur_id] is low in GRANT or COUNT, the next state SHALL be IDLE.
  - gnt clears on the same edge.
  - No done pulse is issued.
  - The arbitration pointer still advances.
REQ-020 A tick_in that coincides with GRANT SHALL be ignored.
REQ-021 Counter arithmetic SHALL be unsigned CNT_W bits and SHALL never wrap below 0.
REQ-022 A requester whose req stays high after its done pulse SHALL be eligible again from the IDLE cycle onward.
REQ-023 Changes to req bits of non-granted requesters SHALL have no effect until the next IDLE.
REQ-024 At most one done bit and at most one gnt bit SHALL be high in any cycle.

Reset
REQ-025 Asserting rst low SHALL immediately force the following values:
  - state=IDLE
  - gnt=0, done=0, busy=0
  - cur_id=0
  - counter=0
  - round-robin pointer=0 (i.e. requester 0 has first priority)
REQ-026 Reset asserted mid-COUNT SHALL abandon the request without a done pulse.
REQ-027 Deassertion of rst SHALL take effect at the next clk edge; arbitration resumes from IDLE.

Configuration
REQ-028 Macro TICK_SCHED_RR_EN, when defined, SHALL select round-robin arbitration.
  - The search starts at index (last granted + 1) mod 4.
  - The pointer updates on exit from DONE or on abort.
REQ-029 With TICK_SCHED_RR_EN undefined, arbitration SHALL be fixed priority (req[0] highest, req[3] lowest).
  - The pointer logic is not built.

Verification
REQ-030 Single request, normal completion:
  - Stimulus: period0=3, req=0001, tick_in every 5th cycle.
  - Required: gnt=0001 one cycle after req; done[0] one cycle after the 3rd tick_in following GRANT; busy low after DONE.
REQ-031 Zero period:
  - Stimulus: period2=0, req=0100.
  - Required: sequence IDLE->GRANT->DONE; done[2] 2 cycles after grant decision; no tick consumed.
REQ-032 Arbitration with all requests held:
  - Stimulus: req=1111 held, all periods=1, tick_in every cycle.
  - Required with TICK_SCHED_RR_EN: grant order 0,1,2,3,0.
  - Required without the macro: grant order 0,0,0.
REQ-033 Abort:
  - Stimulus: period1=10, req=0010; drop req[1] after 4 ticks.
  - Required: gnt=0 and state IDLE next cycle; done stays 0.
REQ-034 Reset mid-COUNT:
  - Stimulus: rst low asynchronously between clk edges during COUNT.
  - Required: gnt, done and busy go to 0 before the next edge; after release with req=1000, requester 3 is granted.
REQ-035 Tick coinciding with GRANT:
  - Stimulus: tick_in=1 on the GRANT cycle, period=1.
  - Required: completion waits for the next tick_in.

Source files
------------

// File: rtl/tick_sched.sv
// tick_sched: four requesters share one tick-driven down counter; each grant times period[id] ticks.
// Define TICK_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority (req[0] highest).
module tick_sched #(
  parameter int CNT_W = 28,
  parameter int NREQ  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_in,
  input  logic [3:0]         req,
  input  logic [4*CNT_W-1:0] period,
  output logic [3:0]         gnt,
  output logic [3:0]         done,
  output logic               busy,
  output logic [1:0]         cur_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cur_id_q, cur_id_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [3:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic [1:0]       arb_base_s;
  logic [2:0]       arb_pick_s;
  logic [CNT_W-1:0] period_sel_s;
  logic             cur_req_s;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Returns {found, index}: first set request scanning upward from base, wrapping mod 4.
  function automatic logic [2:0] arb_pick(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign period_sel_s = period[int'(cur_id_q) * CNT_W +: CNT_W];
  assign cur_req_s    = req[cur_id_q];
  assign arb_pick_s   = arb_pick(req, arb_base_s);

`ifdef TICK_SCHED_RR_EN
  logic [1:0] rr_ptr_q;
  logic       rr_adv_s;

  // The pointer moves past the last owner when it leaves DONE or abandons its request.
  assign rr_adv_s = (state_q == DONE) ||
                    (((state_q == GRANT) || (state_q == COUNT)) && !cur_req_s);

  // Round-robin search origin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= 2'd0;
    end else if (rr_adv_s) begin
      rr_ptr_q <= cur_id_q + 2'd1;
    end else begin
      rr_ptr_q <= rr_ptr_q;
    end
  end

  assign arb_base_s = rr_ptr_q;
`else
  assign arb_base_s = 2'd0;
`endif

  // Next state, counter and registered-output values; abort takes precedence over completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_id_d = cur_id_q;
    gnt_d    = 4'b0000;
    done_d   = 4'b0000;
    case (state_q)
      IDLE: begin
        if (arb_pick_s[2]) begin
          state_d  = GRANT;
          cur_id_d = arb_pick_s[1:0];
          gnt_d    = onehot(arb_pick_s[1:0]);
        end else begin
          state_d  = IDLE;
        end
      end
      GRANT: begin
        if (!cur_req_s) begin
          state_d = IDLE;
        end else if (period_sel_s == {CNT_W{1'b0}}) begin
          state_d = DONE;
          cnt_d   = {CNT_W{1'b0}};
          done_d  = onehot(cur_id_q);
        end else begin
          state_d = COUNT;
          cnt_d   = period_sel_s - CNT_ONE;
          gnt_d   = onehot(cur_id_q);
        end
      end
      COUNT: begin
        if (!cur_req_s) begin
          state_d = IDLE;
        end else if (tick_in && (cnt_q == {CNT_W{1'b0}})) begin
          state_d = DONE;
          done_d  = onehot(cur_id_q);
        end else if (tick_in) begin
          cnt_d   = cnt_q - CNT_ONE;
          gnt_d   = onehot(cur_id_q);
        end else begin
          gnt_d   = onehot(cur_id_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      cur_id_q <= 2'd0;
      gnt_q    <= 4'b0000;
      done_q   <= 4'b0000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_id_q <= cur_id_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign cur_id = cur_id_q;

endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched: vector table, directed corner sequences and random traffic against a
// transaction-level model. Expectations follow TICK_SCHED_RR_EN when it is defined.
module tb_tick_sched;

  localparam int CW = 28;

  logic            clk;
  logic            rst;
  logic            tick_in;
  logic [3:0]      req;
  logic [4*CW-1:0] period;
  logic [3:0]      gnt;
  logic [3:0]      done;
  logic            busy;
  logic [1:0]      cur_id;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: owner (-1 when none), ticks still owed, first-grant-cycle flag, completion flag.
  int         m_owner;
  int         m_left;
  bit         m_fresh;
  bit         m_fin;
  int         m_ptr;
  logic [1:0] m_cur;

  typedef struct {
    logic [3:0] req;
    logic       tick;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       busy;
    logic [1:0] cur;
  } vec_t;

  vec_t tbl[8];

  tick_sched #(.CNT_W(CW), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .req(req), .period(period),
    .gnt(gnt), .done(done), .busy(busy), .cur_id(cur_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_p(input int i, input int v);
    period[i*CW +: CW] = CW'(v);
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_left  = 0;
    m_fresh = 1'b0;
    m_fin   = 1'b0;
    m_ptr   = 0;
    m_cur   = 2'd0;
  endfunction

  function automatic void model_release();
    m_ptr = (int'(m_cur) + 1) % 4;
  endfunction

  function automatic void model_step();
    int base;
    if (m_fin) begin
      m_fin = 1'b0;
      model_release();
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1;
        model_release();
      end else if (m_fresh) begin
        m_fresh = 1'b0;
        m_left  = int'(period[m_owner*CW +: CW]);
        if (m_left == 0) begin
          m_fin = 1'b1; m_owner = -1;
        end
      end else if (tick_in) begin
        m_left--;
        if (m_left == 0) begin
          m_fin = 1'b1; m_owner = -1;
        end
      end
    end else begin
`ifdef TICK_SCHED_RR_EN
      base = m_ptr;
`else
      base = 0;
`endif
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req[(base + k) % 4]) begin
          m_owner = (base + k) % 4;
          m_cur   = 2'(m_owner);
          m_fresh = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [10:0] model_out();
    logic [3:0] g;
    logic [3:0] d;
    g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    d = m_fin ? (4'b0001 << m_cur) : 4'b0000;
    return {g, d, (m_owner >= 0) || m_fin, m_cur};
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
  endtask

  task automatic cycle_chk(input string nm);
    step();
    chk(nm, 32'({gnt, done, busy, cur_id}), 32'(model_out()));
  endtask

  initial begin
    int         nt;
    bit         found;
    int         order[$];
    int         exp_order[5];
    logic [3:0] prev_g;

    rst = 1'b0; req = 4'b0000; tick_in = 1'b0; period = '0;
    model_reset();
    #1;
    chk("reset_outs", 32'({gnt, done, busy, cur_id}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Zero period on requester 2, then tick-on-GRANT with period 1 on requester 3.
    tbl[0] = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd2};
    tbl[1] = '{4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2};
    tbl[2] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2};
    tbl[3] = '{4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 2'd3};
    tbl[4] = '{4'b1000, 1'b1, 4'b1000, 4'b0000, 1'b1, 2'd3};
    tbl[5] = '{4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 2'd3};
    tbl[6] = '{4'b1000, 1'b1, 4'b0000, 4'b1000, 1'b1, 2'd3};
    tbl[7] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd3};
    set_p(2, 0); set_p(3, 1);
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req; tick_in = tbl[i].tick;
      step();
      chk($sformatf("table%0d", i), 32'({gnt, done, busy, cur_id}),
          32'({tbl[i].gnt, tbl[i].done, tbl[i].busy, tbl[i].cur}));
    end

    // Period 3 on requester 0 with a tick every 5th cycle.
    set_p(0, 3); req = 4'b0001; tick_in = 1'b0;
    cycle_chk("req030_model");
    chk("req030_gnt", 32'(gnt), 32'h1);
    nt = 0; found = 1'b0;
    for (int c = 1; c < 80 && !found; c++) begin
      tick_in = (c % 5 == 0);
      cycle_chk("req030_model");
      if (tick_in) nt++;
      if (done[0]) begin
        found = 1'b1;
        chk("req030_ticks", 32'(nt), 32'd3);
        chk("req030_tick_before_done", 32'(tick_in), 32'd1);
      end
    end
    if (!found) chk("req030_timeout", 32'd0, 32'd1);
    tick_in = 1'b0; req = 4'b0000;
    cycle_chk("req030_model");
    chk("req030_busy_low", 32'(busy), 32'd0);

    // All requests held, period 1, tick every cycle; start from a fresh pointer.
    rst = 1'b0; model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_p(i, 1);
`ifdef TICK_SCHED_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    req = 4'b1111; tick_in = 1'b1; prev_g = 4'b0000;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      cycle_chk("req032_model");
      if (gnt != 4'b0000 && prev_g == 4'b0000) order.push_back(oh2i(gnt));
      prev_g = gnt;
    end
    chk("req032_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) chk($sformatf("req032_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    end
    req = 4'b0000; tick_in = 1'b0;
    for (int i = 0; i < 3; i++) cycle_chk("req032_drain");

    // Abort requester 1 after four ticks, then check where arbitration resumes.
    set_p(1, 10); req = 4'b0010;
    cycle_chk("req033_model");
    cycle_chk("req033_model");
    for (int i = 0; i < 4; i++) begin
      tick_in = 1'b1; cycle_chk("req033_model");
      tick_in = 1'b0; cycle_chk("req033_model");
    end
    req = 4'b0000;
    cycle_chk("req033_model");
    chk("req033_gnt", 32'(gnt), 32'd0);
    chk("req033_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle_chk("req033_model");
      chk("req033_no_done", 32'(done), 32'd0);
    end
    req = 4'b0110;
    cycle_chk("req033_model");
`ifdef TICK_SCHED_RR_EN
    chk("req033_next_gnt", 32'(gnt), 32'h4);
`else
    chk("req033_next_gnt", 32'(gnt), 32'h2);
`endif
    req = 4'b0000;
    for (int i = 0; i < 3; i++) cycle_chk("req033_drain");

    // Asynchronous reset in the middle of COUNT.
    set_p(0, 5); req = 4'b0001;
    cycle_chk("req034_model");
    cycle_chk("req034_model");
    #2 rst = 1'b0;
    #1;
    chk("req034_async", 32'({gnt, done, busy}), 32'd0);
    model_reset();
    cycle_chk("req034_in_reset");
    rst = 1'b1; req = 4'b1000;
    cycle_chk("req034_model");
    chk("req034_regrant", 32'({gnt, cur_id}), 32'({4'b1000, 2'd3}));
    req = 4'b0000;
    for (int i = 0; i < 3; i++) cycle_chk("req034_drain");

    // Random traffic against the model.
    for (int i = 0; i < 4; i++) set_p(i, int'($urandom_range(4, 1)));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      tick_in = 1'($urandom);
      if ($urandom_range(15) == 0) set_p(int'($urandom_range(3)), int'($urandom_range(5)));
      cycle_chk("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
